// File: rtl/lift_pkg.sv
// lift_pkg: shared types and default sizing for the lift call scheduler.
//
// Contents:
//   NumFloorsDefault  - default number of served floors
//   FloorWDefault     - default width of a floor index
//   DoorCyclesDefault - default number of clocks the door stays open per stop
//   sched_state_e     - scheduler state (idle, travelling to a target, door open)
package lift_pkg;

   localparam int unsigned NumFloorsDefault  = 4;
   localparam int unsigned FloorWDefault     = 2;
   localparam int unsigned DoorCyclesDefault = 8;

   typedef enum logic [1:0] {
      StIdle,
      StMove,
      StDoor
   } sched_state_e;

endpackage

// File: rtl/lift_next_target.sv
// lift_next_target: combinational SCAN target selector.
//
// Given the pending call set, the lift position and the current travel direction, returns the
// nearest pending floor ahead of the lift. If nothing is pending ahead, it returns the nearest
// pending floor behind the lift together with the reversed direction. The floor the lift is on
// is never selected.
//
// Ports:
//   pending       in   NUM_FLOORS  outstanding calls
//   current_floor in   FLOOR_W     floor the lift is at
//   dir_up        in   1           current travel direction (1 = up)
//   found         out  1           a target exists
//   floor         out  FLOOR_W     selected target floor (0 when none)
//   new_dir       out  1           direction needed to reach floor (dir_up when none)
module lift_next_target
   import lift_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = NumFloorsDefault,
   parameter int unsigned FLOOR_W    = FloorWDefault
) (
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  dir_up,
   output logic                  found,
   output logic [FLOOR_W-1:0]    floor,
   output logic                  new_dir
);

   logic               up_found;
   logic               dn_found;
   logic [FLOOR_W-1:0] up_floor;
   logic [FLOOR_W-1:0] dn_floor;

   // Ascending scan: the first hit above is the nearest one above, the last hit below is the
   // nearest one below. An out-of-range current_floor simply has nothing above it.
   always_comb begin
      up_found = 1'b0;
      dn_found = 1'b0;
      up_floor = '0;
      dn_floor = '0;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         if (pending[i] && (FLOOR_W'(i) > current_floor) && !up_found) begin
            up_found = 1'b1;
            up_floor = FLOOR_W'(i);
         end
         if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
            dn_found = 1'b1;
            dn_floor = FLOOR_W'(i);
         end
      end
   end

   always_comb begin
      found   = 1'b0;
      floor   = '0;
      new_dir = dir_up;
      if (dir_up) begin
         if (up_found) begin
            found   = 1'b1;
            floor   = up_floor;
            new_dir = 1'b1;
         end else if (dn_found) begin
            found   = 1'b1;
            floor   = dn_floor;
            new_dir = 1'b0;
         end
      end else begin
         if (dn_found) begin
            found   = 1'b1;
            floor   = dn_floor;
            new_dir = 1'b0;
         end else if (up_found) begin
            found   = 1'b1;
            floor   = up_floor;
            new_dir = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: floor-call scheduler in front of the lift controller.
//
// Latches button calls into a pending set, picks targets in SCAN order (keep going the same way
// while calls remain ahead, then reverse), drives the lift target and runs a timed door-open
// phase at every served floor.
//
// Optional build macro: LIFT_SCHED_STATS_EN adds a saturating 16-bit stop counter output.
//
// Ports:
//   clk           in   1           system clock, rising edge
//   rst           in   1           asynchronous active-high reset
//   call_req      in   NUM_FLOORS  call per floor, sampled every clock
//   current_floor in   FLOOR_W     floor reported by the lift
//   at_floor      in   1           lift stationary at current_floor
//   target_floor  out  FLOOR_W     floor the lift must travel to
//   target_valid  out  1           target_floor meaningful; lift moves only while high
//   door_open     out  1           door open phase active
//   dir_up        out  1           current SCAN direction (1 = up)
//   pending       out  NUM_FLOORS  outstanding calls
//   busy          out  1           scheduler not idle
//   stop_count    out  16          stops served, saturating (LIFT_SCHED_STATS_EN only)
module lift_call_scheduler
   import lift_pkg::*;
#(
   parameter int unsigned NUM_FLOORS  = NumFloorsDefault,
   parameter int unsigned FLOOR_W     = FloorWDefault,
   parameter int unsigned DOOR_CYCLES = DoorCyclesDefault
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [FLOOR_W-1:0]    current_floor,
   input  logic                  at_floor,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  target_valid,
   output logic                  door_open,
   output logic                  dir_up,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  busy
`ifdef LIFT_SCHED_STATS_EN
   ,
   output logic [15:0]           stop_count
`endif
);

   localparam int unsigned     CntW     = $clog2(DOOR_CYCLES + 1);
   localparam logic [CntW-1:0] DoorLoad = CntW'(DOOR_CYCLES);

   sched_state_e          state_q, state_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [FLOOR_W-1:0]    target_q, target_d;
   logic                  dir_q, dir_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [NUM_FLOORS-1:0] clear_mask;

   logic [NUM_FLOORS-1:0] cur_onehot;
   logic                  cur_pending;
   logic                  cur_call;

   logic                  sel_found;
   logic [FLOOR_W-1:0]    sel_floor;
   logic                  sel_dir;
   logic                  retarget;

   // One-hot of the lift position; all zero when current_floor names a floor that does not exist.
   always_comb begin
      cur_onehot = '0;
      for (int i = 0; i < int'(NUM_FLOORS); i++) begin
         cur_onehot[i] = (current_floor == FLOOR_W'(i));
      end
   end

   assign cur_pending = |(pending_q & cur_onehot);
   assign cur_call    = |(call_req & cur_onehot);

   // Shared selector: picks the next stop in IDLE, and while moving it yields the nearest pending
   // floor ahead, which is a retarget candidate when it sits before the current target.
   lift_next_target #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_next_target (
      .pending       (pending_q),
      .current_floor (current_floor),
      .dir_up        (dir_q),
      .found         (sel_found),
      .floor         (sel_floor),
      .new_dir       (sel_dir)
   );

   assign retarget = sel_found && (sel_dir == dir_q) &&
                     (dir_q ? (sel_floor < target_q) : (sel_floor > target_q));

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      clear_mask = '0;
      case (state_q)
         StIdle: begin
            if (at_floor && cur_pending) begin
               clear_mask = cur_onehot;
               cnt_d      = DoorLoad;
               state_d    = StDoor;
            end else if (sel_found) begin
               target_d = sel_floor;
               dir_d    = sel_dir;
               state_d  = StMove;
            end
         end
         StMove: begin
            if (at_floor && (current_floor == target_q)) begin
               // Lift is on the target, so the current-floor one-hot is the target bit.
               clear_mask = cur_onehot;
               cnt_d      = DoorLoad;
               state_d    = StDoor;
            end else if (retarget) begin
               target_d = sel_floor;
            end
         end
         StDoor: begin
            // Calls for the open floor are absorbed: they hold the door instead of queueing.
            clear_mask = cur_onehot;
            if (cur_call) begin
               cnt_d = DoorLoad;
            end else if (cnt_q <= CntW'(1)) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      pending_d = (pending_q | call_req) & ~clear_mask;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         pending_q <= '0;
         target_q  <= '0;
         dir_q     <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         target_q  <= target_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
      end
   end

   assign target_floor = target_q;
   assign target_valid = (state_q == StMove);
   assign door_open    = (state_q == StDoor);
   assign dir_up       = dir_q;
   assign pending      = pending_q;
   assign busy         = (state_q != StIdle);

`ifdef LIFT_SCHED_STATS_EN
   logic [15:0] stop_count_q;
   logic        enter_door;

   assign enter_door = (state_d == StDoor) && (state_q != StDoor);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stop_count_q <= '0;
      end else if (enter_door && (stop_count_q != 16'hFFFF)) begin
         stop_count_q <= stop_count_q + 16'd1;
      end
   end

   assign stop_count = stop_count_q;
`else
   // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb_lift_call_scheduler: self-checking bench for lift_call_scheduler.
//
// A simple lift model (one floor per four clocks) follows the scheduler's target. A behavioural
// reference model of the scheduler predicts every output each cycle; directed table vectors and
// hand-written sequences add checks against hand-computed constants.
module tb_lift_call_scheduler;

   localparam int NF         = 4;
   localparam int FW         = 2;
   localparam int DC         = 8;
   localparam int LIFT_TICKS = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NF-1:0] call_req;
   logic [FW-1:0] current_floor;
   logic          at_floor;
   logic [FW-1:0] target_floor;
   logic          target_valid;
   logic          door_open;
   logic          dir_up;
   logic [NF-1:0] pending;
   logic          busy;
`ifdef LIFT_SCHED_STATS_EN
   logic [15:0]   stop_count;
`endif

   lift_call_scheduler #(
      .NUM_FLOORS  (NF),
      .FLOOR_W     (FW),
      .DOOR_CYCLES (DC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .call_req      (call_req),
      .current_floor (current_floor),
      .at_floor      (at_floor),
      .target_floor  (target_floor),
      .target_valid  (target_valid),
      .door_open     (door_open),
      .dir_up        (dir_up),
      .pending       (pending),
      .busy          (busy)
`ifdef LIFT_SCHED_STATS_EN
      ,
      .stop_count    (stop_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: calls as a per-floor array, travelling flag, door time left.
   bit m_pend[NF];
   bit m_moving;
   int m_door_left;
   int m_tgt;
   bit m_dir;
   int m_stops;

   int lift_pos;
   int lift_tick;

   typedef struct {
      logic [NF-1:0] req;
      bit            exp_valid;
      bit            exp_door;
      int            exp_tgt;
      bit            exp_dir;
      int            exp_floor;
      bit            exp_fdir;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
      m_moving    = 1'b0;
      m_door_left = 0;
      m_tgt       = 0;
      m_dir       = 1'b1;
      m_stops     = 0;
   endtask

   function automatic logic [NF-1:0] pend_vec();
      logic [NF-1:0] v = '0;
      for (int f = 0; f < NF; f++) v[f] = m_pend[f];
      return v;
   endfunction

   task automatic add_calls(input int skip);
      for (int f = 0; f < NF; f++) if (call_req[f] && f != skip) m_pend[f] = 1'b1;
   endtask

   // Predicts the effect of the coming clock edge from the present inputs.
   task automatic model_step();
      int cur = int'(current_floor);
      bit found = 1'b0;
      bit d0 = m_dir;
      int f;
      if (m_door_left > 0) begin
         add_calls(cur);
         if (call_req[cur]) m_door_left = DC;
         else m_door_left--;
      end else if (m_moving) begin
         if (at_floor && cur == m_tgt) begin
            add_calls(-1);
            m_pend[m_tgt] = 1'b0;
            m_moving      = 1'b0;
            m_door_left   = DC;
            m_stops++;
         end else begin
            for (int d = 1; d < NF && !found; d++) begin
               f = d0 ? cur + d : cur - d;
               if (f == m_tgt || f < 0 || f >= NF) break;
               if (m_pend[f]) begin
                  m_tgt = f;
                  found = 1'b1;
               end
            end
            add_calls(-1);
         end
      end else begin
         if (at_floor && m_pend[cur]) begin
            add_calls(-1);
            m_pend[cur] = 1'b0;
            m_door_left = DC;
            m_stops++;
         end else begin
            for (int d = 1; d < NF && !found; d++) begin
               f = d0 ? cur + d : cur - d;
               if (f >= 0 && f < NF && m_pend[f]) begin
                  m_tgt = f;
                  found = 1'b1;
               end
            end
            for (int d = 1; d < NF && !found; d++) begin
               f = d0 ? cur - d : cur + d;
               if (f >= 0 && f < NF && m_pend[f]) begin
                  m_tgt = f;
                  m_dir = !d0;
                  found = 1'b1;
               end
            end
            if (found) m_moving = 1'b1;
            add_calls(-1);
         end
      end
   endtask

   task automatic check_model();
      chk("target_valid", target_valid, m_moving);
      chk("door_open", door_open, m_door_left > 0);
      chk("busy", busy, m_moving || (m_door_left > 0));
      chk("dir_up", dir_up, m_dir);
      chk("target_floor", target_floor, m_tgt);
      chk("pending", pending, pend_vec());
`ifdef LIFT_SCHED_STATS_EN
      chk("stop_count", stop_count, m_stops);
`endif
   endtask

   // Lift follows the scheduler's target one floor per LIFT_TICKS clocks.
   task automatic lift_update();
      int tgt = int'(target_floor);
      if (target_valid && tgt != lift_pos) begin
         lift_tick++;
         if (lift_tick == LIFT_TICKS) begin
            lift_pos  = (tgt > lift_pos) ? lift_pos + 1 : lift_pos - 1;
            lift_tick = 0;
         end
      end else begin
         lift_tick = 0;
      end
      current_floor = FW'(lift_pos);
      at_floor      = !(target_valid && (tgt != lift_pos));
   endtask

   task automatic step(input logic [NF-1:0] req);
      call_req = req;
      model_step();
      @(negedge clk);
      check_model();
      lift_update();
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      while ((busy || pending != '0) && n < budget) begin
         step('0);
         n++;
      end
      chk("settle_timeout", busy | (|pending), 1'b0);
   endtask

   task automatic wait_door(input string name, input int budget);
      int n = 0;
      while (!door_open && n < budget) begin
         step('0);
         n++;
      end
      chk(name, door_open, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog at %0t: got no finish expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [NF-1:0] req;

      vecs[0] = '{4'b0100, 1'b1, 1'b0, 2, 1'b1, 2, 1'b1};
      vecs[1] = '{4'b1001, 1'b1, 1'b0, 3, 1'b1, 0, 1'b0};
      vecs[2] = '{4'b0010, 1'b1, 1'b0, 1, 1'b1, 1, 1'b1};
      vecs[3] = '{4'b0001, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0};
      vecs[4] = '{4'b0001, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0};
      vecs[5] = '{4'b1100, 1'b1, 1'b0, 2, 1'b1, 3, 1'b1};
      vecs[6] = '{4'b0011, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0};

      call_req      = '0;
      lift_pos      = 0;
      lift_tick     = 0;
      current_floor = '0;
      at_floor      = 1'b1;
      model_reset();

      // Reset hold and release.
      repeat (3) @(negedge clk);
      chk("rst_target_floor", target_floor, 0);
      chk("rst_target_valid", target_valid, 0);
      chk("rst_door_open", door_open, 0);
      chk("rst_dir_up", dir_up, 1);
      chk("rst_pending", pending, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step('0);
         chk("idle_busy", busy, 0);
      end

      // Directed selection vectors, chained from one settled position to the next.
      for (int i = 0; i < 7; i++) begin
         step(vecs[i].req);
         step('0);
         chk("vec_valid", target_valid, vecs[i].exp_valid);
         chk("vec_door", door_open, vecs[i].exp_door);
         if (vecs[i].exp_valid) chk("vec_target", target_floor, vecs[i].exp_tgt);
         chk("vec_dir", dir_up, vecs[i].exp_dir);
         run_until_idle(400);
         chk("vec_floor", lift_pos, vecs[i].exp_floor);
         chk("vec_final_dir", dir_up, vecs[i].exp_fdir);
      end

      // Retarget: travelling 0 -> 3, a call for 2 arrives while passing floor 1.
      step(4'b1000);
      step('0);
      chk("rt_first_target", target_floor, 3);
      n = 0;
      while (lift_pos != 1 && n < 200) begin
         step('0);
         n++;
      end
      chk("rt_reach_floor1", lift_pos, 1);
      step(4'b0100);
      step('0);
      chk("rt_retarget", target_floor, 2);
      chk("rt_pending", pending, 4'b1100);
      wait_door("rt_door_timeout", 200);
      chk("rt_stop_floor", lift_pos, 2);
      n = 0;
      while (door_open && n < 40) begin
         n++;
         step('0);
      end
      chk("rt_door_len", n, DC);
      n = 0;
      while (!target_valid && n < 20) begin
         step('0);
         n++;
      end
      chk("rt_next_target", target_floor, 3);
      run_until_idle(400);

      // Door restart at floor 1: a call for the open floor two clocks into the door phase.
      step(4'b0010);
      wait_door("dr_door_timeout", 200);
      chk("dr_stop_floor", lift_pos, 1);
      step('0);
      step('0);
      step(4'b0010);
      chk("dr_pending1", pending[1], 1'b0);
      n = 3;
      while (door_open && n < 60) begin
         n++;
         step('0);
      end
      chk("dr_door_len", n, 3 + DC);
      run_until_idle(400);

      // Asynchronous reset while travelling toward 3 with a call waiting behind.
      step(4'b1000);
      step('0);
      step(4'b0001);
      step('0);
      chk("mt_moving", target_valid, 1);
      chk("mt_pending_pre", pending, 4'b1001);
      #1 rst = 1'b1;
      #1;
      chk("mt_target_valid", target_valid, 0);
      chk("mt_target_floor", target_floor, 0);
      chk("mt_pending", pending, 0);
      chk("mt_busy", busy, 0);
      chk("mt_door_open", door_open, 0);
      chk("mt_dir_up", dir_up, 1);
      model_reset();
      lift_tick = 0;
      at_floor  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step('0);

      // Random calls against the reference model.
      for (int i = 0; i < 2500; i++) begin
         req = ($urandom_range(0, 5) == 0) ? NF'($urandom_range(1, 15)) : '0;
         step(req);
      end
      run_until_idle(800);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
